// File: rtl/cacheline_adaptor_if.sv
// Line-request and memory-burst signals between the cache arbiter, the adaptor and physical memory.
// The adaptor takes the slave view; the arbiter and memory side together take the master view.
interface cacheline_adaptor_if #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
);
    logic [ADDR_W-1:0]  address_i;
    logic               read_i;
    logic               write_i;
    logic [LINE_W-1:0]  line_i;
    logic [LINE_W-1:0]  line_o;
    logic               resp_o;
    logic [ADDR_W-1:0]  address_o;
    logic               read_o;
    logic               write_o;
    logic [BURST_W-1:0] burst_o;
    logic [BURST_W-1:0] burst_i;
    logic               resp_i;

    modport slave (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    modport master (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one line-wide read/write from the cache arbiter into a BEATS-long memory burst
// and answers upstream with a single-cycle resp_o.
//
// state | meaning
// IDLE  | waiting for read_i/write_i; read wins when both are high
// READ  | read_o high, storing one beat per resp_i into the line buffer
// WRITE | write_o high, presenting buffer slice cnt until its resp_i
// DONE  | resp_o high for one cycle, then back to IDLE
module cacheline_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64,
    parameter int ADDR_W  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    cacheline_adaptor_if.slave bus
);
    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(LINE_W / 8 - 1);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [LINE_W-1:0]  line_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               read_q;
    logic               write_q;
    logic               resp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    resp_q <= 1'b0;
                    if (bus.read_i) begin
                        addr_q <= bus.address_i & ~OFF_MASK;
                        cnt    <= '0;
                        read_q <= 1'b1;
                        state  <= READ;
                    end else if (bus.write_i) begin
                        addr_q  <= bus.address_i & ~OFF_MASK;
                        line_q  <= bus.line_i;
                        cnt     <= '0;
                        write_q <= 1'b1;
                        state   <= WRITE;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        line_q[cnt*BURST_W +: BURST_W] <= bus.burst_i;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            read_q <= 1'b0;
                            resp_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    resp_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // All outputs come straight from registers, so reset clears them without waiting for a clock.
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;
    assign bus.address_o = addr_q;
    assign bus.line_o    = line_q;
    assign bus.burst_o   = line_q[cnt*BURST_W +: BURST_W];
endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: zero-wait and stalled reads, stalled write,
// read/write collision and reset in the middle of a burst.
module tb_cacheline_adaptor;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cacheline_adaptor_if #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) bus_if ();

    cacheline_adaptor #(.LINE_W(LINE_W), .BURST_W(BURST_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.read_i    = 1'b0;
        bus_if.write_i   = 1'b0;
        bus_if.resp_i    = 1'b0;
        bus_if.burst_i   = '0;
        bus_if.address_i = '0;
        bus_if.line_i    = '0;
    endtask

    // pat bit c-1 is resp_i for burst cycle c; it must hold exactly four ones.
    task automatic read_burst(input logic [31:0] addr, input logic [31:0] exp_addr,
                              input logic [15:0] pat, input int n_cyc,
                              input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] b2, input logic [63:0] b3,
                              input logic [255:0] prev_line, input logic wr_too);
        logic [63:0]  beats [4];
        logic [255:0] exp_line;
        int b;
        beats    = '{b0, b1, b2, b3};
        exp_line = {b3, b2, b1, b0};
        b = 0;
        @(negedge clk);
        bus_if.read_i    = 1'b1;
        bus_if.write_i   = wr_too;
        bus_if.address_i = addr;
        bus_if.line_i    = {4{64'hA5A5_5A5A_C3C3_3C3C}};
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge clk);
            check_val("rd_read_o", 256'(bus_if.read_o), 256'd1);
            check_val("rd_write_o", 256'(bus_if.write_o), 256'd0);
            check_val("rd_resp_early", 256'(bus_if.resp_o), 256'd0);
            check_val("rd_address_o", 256'(bus_if.address_o), 256'(exp_addr));
            if (c == 1) check_val("rd_line_before", bus_if.line_o, prev_line);
            if (pat[c-1]) begin
                bus_if.resp_i  = 1'b1;
                bus_if.burst_i = beats[b];
                b++;
            end else begin
                bus_if.resp_i  = 1'b0;
                bus_if.burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
            end
        end
        @(negedge clk);
        bus_if.resp_i = 1'b0;
        check_val("rd_resp_o", 256'(bus_if.resp_o), 256'd1);
        check_val("rd_done_read_o", 256'(bus_if.read_o), 256'd0);
        check_val("rd_line_o", bus_if.line_o, exp_line);
        bus_if.read_i  = 1'b0;
        bus_if.write_i = 1'b0;
        @(negedge clk);
        check_val("rd_resp_once", 256'(bus_if.resp_o), 256'd0);
        check_val("rd_idle_read_o", 256'(bus_if.read_o), 256'd0);
        check_val("rd_line_hold", bus_if.line_o, exp_line);
        bus_if.resp_i  = 1'b1;
        bus_if.burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        bus_if.resp_i = 1'b0;
        check_val("rd_idle_resp_i_ignored", bus_if.line_o, exp_line);
        check_val("rd_idle_resp_o", 256'(bus_if.resp_o), 256'd0);
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [31:0] exp_addr,
                               input logic [255:0] line,
                               input logic [63:0] s0, input logic [63:0] s1,
                               input logic [63:0] s2, input logic [63:0] s3,
                               input logic [15:0] pat, input int n_cyc);
        logic [63:0] slices [4];
        int b;
        slices = '{s0, s1, s2, s3};
        b = 0;
        @(negedge clk);
        bus_if.write_i   = 1'b1;
        bus_if.address_i = addr;
        bus_if.line_i    = line;
        for (int c = 1; c <= n_cyc; c++) begin
            @(negedge clk);
            check_val("wr_write_o", 256'(bus_if.write_o), 256'd1);
            check_val("wr_read_o", 256'(bus_if.read_o), 256'd0);
            check_val("wr_resp_early", 256'(bus_if.resp_o), 256'd0);
            check_val("wr_address_o", 256'(bus_if.address_o), 256'(exp_addr));
            check_val("wr_burst_o", 256'(bus_if.burst_o), 256'(slices[b]));
            bus_if.resp_i = pat[c-1];
            if (pat[c-1]) b++;
        end
        @(negedge clk);
        bus_if.resp_i = 1'b0;
        check_val("wr_done_write_o", 256'(bus_if.write_o), 256'd0);
        check_val("wr_resp_o", 256'(bus_if.resp_o), 256'd1);
        check_val("wr_line_buf", bus_if.line_o, line);
        bus_if.write_i = 1'b0;
        @(negedge clk);
        check_val("wr_resp_once", 256'(bus_if.resp_o), 256'd0);
        check_val("wr_idle_write_o", 256'(bus_if.write_o), 256'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        #3;
        check_val("rst_read_o", 256'(bus_if.read_o), 256'd0);
        check_val("rst_write_o", 256'(bus_if.write_o), 256'd0);
        check_val("rst_resp_o", 256'(bus_if.resp_o), 256'd0);
        check_val("rst_address_o", 256'(bus_if.address_o), 256'd0);
        check_val("rst_burst_o", 256'(bus_if.burst_o), 256'd0);
        check_val("rst_line_o", bus_if.line_o, 256'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_val("idle_read_o", 256'(bus_if.read_o), 256'd0);
            check_val("idle_write_o", 256'(bus_if.write_o), 256'd0);
        end

        // zero-wait read: resp_o in cycle 5
        read_burst(32'h0000_1234, 32'h0000_1220, 16'b1111, 4,
                   64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
                   256'd0, 1'b0);

        // two idle cycles before beats 1 and 3: resp_o in cycle 9
        read_burst(32'h0000_1234, 32'h0000_1220, 16'b1001_1001, 8,
                   64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444,
                   {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0);

        write_burst(32'hCAFE_F00D, 32'hCAFE_F000,
                    256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF,
                    64'h8899AABBCCDDEEFF, 64'h0011223344556677,
                    64'hFEDCBA9876543210, 64'h0123456789ABCDEF,
                    16'b10_1101, 6);

        // read and write together: read wins, buffer keeps the last write line until beats arrive
        read_burst(32'h0000_0040, 32'h0000_0040, 16'b1111, 4,
                   64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                   64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888,
                   256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_8899AABBCCDDEEFF, 1'b1);

        // reset after two read beats
        @(negedge clk);
        bus_if.read_i    = 1'b1;
        bus_if.address_i = 32'h0000_805F;
        @(negedge clk);
        bus_if.resp_i  = 1'b1;
        bus_if.burst_i = 64'hAAAA_AAAA_AAAA_AAAA;
        @(negedge clk);
        bus_if.burst_i = 64'hBBBB_BBBB_BBBB_BBBB;
        @(negedge clk);
        bus_if.resp_i = 1'b0;
        check_val("pre_rst_read_o", 256'(bus_if.read_o), 256'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_read_o", 256'(bus_if.read_o), 256'd0);
        check_val("mid_rst_resp_o", 256'(bus_if.resp_o), 256'd0);
        check_val("mid_rst_address_o", 256'(bus_if.address_o), 256'd0);
        check_val("mid_rst_burst_o", 256'(bus_if.burst_o), 256'd0);
        check_val("mid_rst_line_o", bus_if.line_o, 256'd0);
        bus_if.read_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("post_rst_no_resp", 256'(bus_if.resp_o), 256'd0);
            check_val("post_rst_read_o", 256'(bus_if.read_o), 256'd0);
        end
        read_burst(32'h0000_805F, 32'h0000_8040, 16'b1111, 4,
                   64'hC0C0_C0C0_C0C0_C0C0, 64'hD1D1_D1D1_D1D1_D1D1,
                   64'hE2E2_E2E2_E2E2_E2E2, 64'hF3F3_F3F3_F3F3_F3F3,
                   256'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
